// File: rtl/io_slave_pkg.sv
// Shared types and constants for the io_slave_if bus responder.
package io_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

endpackage

// File: rtl/io_slave_decode.sv
// Address-window decode: a live bus cycle aimed at this device's window with chip select asserted.
module io_slave_decode #(
    parameter logic [31:0] BASE = 32'hFD0A0000,
    parameter logic [31:0] MASK = 32'hFFFF0000
) (
    input  logic        cs_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [31:0] adr_i,
    output logic        hit_o
);

    assign hit_o = cyc_i & stb_i & cs_i & ((adr_i & MASK) == (BASE & MASK));

endmodule

// File: rtl/io_slave_if.sv
// Device-side responder turning bridge cyc/stb cycles into one-cycle register strobes.
// Define IOSLV_FAST_WR_EN to post writes (IDLE->ACK directly, retired later by reg_rdy_i).
module io_slave_if
    import io_slave_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'hFD0A0000,
    parameter logic [31:0] MASK        = 32'hFFFF0000,
    parameter int          ABITS       = 6,
    parameter int          WAIT_STATES = 1,
    parameter int          TIMEOUT     = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    output logic             ack_o,
    output logic             stall_o,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             reg_rd_o,
    output logic             reg_wr_o,
    output logic [ABITS-1:0] reg_adr_o,
    output logic [3:0]       reg_sel_o,
    output logic [31:0]      reg_dat_o,
    input  logic [31:0]      reg_dat_i,
    input  logic             reg_rdy_i,
    output logic             err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    logic [3:0]    wait_q, wait_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdy_seen_q, rdy_seen_d;
    logic          ack_q, ack_d;
    logic          stall_q, stall_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic          hit, accept, held;
    logic          bus_live, wait_done, tmo_done;

    io_slave_decode #(
        .BASE (BASE),
        .MASK (MASK)
    ) u_decode (
        .cs_i  (cs_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .adr_i (adr_i),
        .hit_o (hit)
    );

`ifdef IOSLV_FAST_WR_EN
    // A posted write stays pending until the device reports completion; new cycles wait for it.
    logic pend_q, pend_d;

    assign accept = hit & ~(pend_q & ~reg_rdy_i);
    assign held   = hit & ~accept;
    assign pend_d = ((state_q == IDLE) & accept & we_i) | (pend_q & ~reg_rdy_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    assign accept = hit;
    assign held   = 1'b0;
`endif

    assign bus_live  = cyc_i & stb_i;
    assign wait_done = (wait_q <= 4'd1);
    assign tmo_done  = (tmo_q <= TW'(1));

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wait_d     = wait_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        rdy_seen_d = rdy_seen_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d      = '{we: we_i, sel: sel_i, adr: adr_i, dat: dat_i};
                    rd_d       = ~we_i;
                    wr_d       = we_i;
                    wait_d     = 4'(WAIT_STATES);
                    tmo_d      = TW'(TIMEOUT);
                    rdata_d    = '0;
                    rdy_seen_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = WAIT;
`ifdef IOSLV_FAST_WR_EN
                    if (we_i) begin
                        state_d = ACK;
                    end
`endif
                end
            end
            WAIT: begin
                if (!bus_live) begin
                    state_d = IDLE;
                end else begin
                    wait_d = (wait_q != 4'd0) ? wait_q - 4'd1 : 4'd0;
                    tmo_d  = tmo_q - TW'(1);
                    if (reg_rdy_i) begin
                        rdy_seen_d = 1'b1;
                        if (!req_q.we) begin
                            rdata_d = reg_dat_i;
                        end
                    end
                    // Completion wins over a timeout expiring in the same cycle.
                    if (wait_done && (reg_rdy_i || rdy_seen_q)) begin
                        state_d = ACK;
                    end else if (tmo_done) begin
                        state_d = ACK;
                        err_d   = 1'b1;
                        if (!req_q.we) begin
                            rdata_d = TIMEOUT_DATA;
                        end
                    end
                end
            end
            ACK: begin
                if (!stb_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ack_d   = (state_d == ACK);
        stall_d = (state_d != IDLE) | held;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            wait_q     <= '0;
            tmo_q      <= '0;
            rdata_q    <= '0;
            rdy_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            stall_q    <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wait_q     <= wait_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
            rdy_seen_q <= rdy_seen_d;
            ack_q      <= ack_d;
            stall_q    <= stall_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
        end
    end

    logic unused_adr_bits;
    assign unused_adr_bits = ^{req_q.adr[31:ABITS+2], req_q.adr[1:0]};

    assign ack_o     = ack_q;
    assign stall_o   = stall_q;
    assign reg_rd_o  = rd_q;
    assign reg_wr_o  = wr_q;
    assign reg_adr_o = req_q.adr[ABITS+1:2];
    assign reg_sel_o = req_q.sel;
    assign reg_dat_o = req_q.dat;
    assign err_o     = err_q;
    assign dat_o     = ack_q ? rdata_q : 32'd0;

endmodule

// File: tb/tb_io_slave_if.sv
// Directed bench for io_slave_if: a WAIT_STATES=1 instance plus a WAIT_STATES=3 instance on shared inputs.
module tb_io_slave_if;

    localparam logic [31:0] BASE = 32'hFD0A0000;
`ifdef IOSLV_FAST_WR_EN
    localparam logic FAST = 1'b1;
`else
    localparam logic FAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cs_i, cyc_i, stb_i, we_i, reg_rdy_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i, dat_i, reg_dat_i;

    logic        ack_o, stall_o, reg_rd_o, reg_wr_o, err_o;
    logic [31:0] dat_o, reg_dat_o;
    logic [5:0]  reg_adr_o;
    logic [3:0]  reg_sel_o;

    logic        ack3, stall3;
    logic [31:0] dat3;
    logic        unusedRd3, unusedWr3, unusedErr3;
    logic [5:0]  unusedAdr3;
    logic [3:0]  unusedSel3;
    logic [31:0] unusedDat3;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk_i = ~clk_i;

    io_slave_if u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_o(ack_o), .stall_o(stall_o), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i),
        .dat_i(dat_i), .dat_o(dat_o), .reg_rd_o(reg_rd_o), .reg_wr_o(reg_wr_o),
        .reg_adr_o(reg_adr_o), .reg_sel_o(reg_sel_o), .reg_dat_o(reg_dat_o),
        .reg_dat_i(reg_dat_i), .reg_rdy_i(reg_rdy_i), .err_o(err_o)
    );

    io_slave_if #(.WAIT_STATES(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_o(ack3), .stall_o(stall3), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i),
        .dat_i(dat_i), .dat_o(dat3), .reg_rd_o(unusedRd3), .reg_wr_o(unusedWr3),
        .reg_adr_o(unusedAdr3), .reg_sel_o(unusedSel3), .reg_dat_o(unusedDat3),
        .reg_dat_i(reg_dat_i), .reg_rdy_i(reg_rdy_i), .err_o(unusedErr3)
    );

    // Counts one comparison and reports it when the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives the bus-side inputs in one go.
    task automatic applyStimulus(input logic cyc, input logic stb, input logic cs, input logic we,
                                 input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        cyc_i = cyc;
        stb_i = stb;
        cs_i  = cs;
        we_i  = we;
        sel_i = sel;
        adr_i = adr;
        dat_i = dat;
    endtask

    // Advances one clock and settles just after the edge, so cycle N is observed between edges.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs several cycles with the current inputs and returns whether anything responded.
    task automatic watchIdle(input int cycles, output logic activity);
        activity = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            activity = activity | ack_o | stall_o | reg_rd_o | reg_wr_o | ack3 | stall3;
        end
    endtask

    int   earlyAck;
    logic activity;

    initial begin
        $display("[TB] starting io_slave_if bench");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reg_rdy_i = 1'b0;
        reg_dat_i = 32'h0;
        rst_i     = 1'b1;
        tick();
        tick();

        // Reset state
        checkOutput("rst_ack", ack_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_dat", dat_o, 0);
        checkOutput("rst_rd", reg_rd_o, 0);
        checkOutput("rst_wr", reg_wr_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_adr", reg_adr_o, 0);
        checkOutput("rst_regdat", reg_dat_o, 0);
        rst_i = 1'b0;
        tick();

        // Read at BASE+8 with reg_rdy_i tied high
        reg_rdy_i = 1'b1;
        reg_dat_i = 32'h12345678;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'd8, 32'h0);
        checkOutput("rd_stall_c0", stall_o, 0);
        tick();
        checkOutput("rd_strobe_c1", reg_rd_o, 1);
        checkOutput("rd_nowr_c1", reg_wr_o, 0);
        checkOutput("rd_adr_c1", reg_adr_o, 2);
        checkOutput("rd_ack_c1", ack_o, 0);
        checkOutput("rd_stall_c1", stall_o, 1);
        tick();
        checkOutput("rd_ack_c2", ack_o, 1);
        checkOutput("rd_dat_c2", dat_o, 32'h12345678);
        checkOutput("rd_strobe_c2", reg_rd_o, 0);
        checkOutput("ws3_ack_c2", ack3, 0);
        tick();
        checkOutput("rd_ack_hold_c3", ack_o, 1);
        checkOutput("ws3_ack_c3", ack3, 0);
        tick();
        checkOutput("ws3_ack_c4", ack3, 1);
        checkOutput("ws3_dat_c4", dat3, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'd8, 32'h0);
        tick();
        checkOutput("rd_ack_drop", ack_o, 0);
        checkOutput("rd_dat_drop", dat_o, 0);
        checkOutput("rd_stall_drop", stall_o, 0);
        checkOutput("ws3_ack_drop", ack3, 0);
        tick();

        // Write at BASE+4
        reg_dat_i = 32'h55AA55AA;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, BASE + 32'd4, 32'hCAFEF00D);
        tick();
        checkOutput("wr_strobe_c1", reg_wr_o, 1);
        checkOutput("wr_nord_c1", reg_rd_o, 0);
        checkOutput("wr_sel_c1", reg_sel_o, 4'b0011);
        checkOutput("wr_regdat_c1", reg_dat_o, 32'hCAFEF00D);
        checkOutput("wr_adr_c1", reg_adr_o, 1);
        checkOutput("wr_ack_c1", ack_o, FAST);
        checkOutput("wr_dat_c1", dat_o, 0);
        tick();
        checkOutput("wr_ack_c2", ack_o, 1);
        checkOutput("wr_dat_c2", dat_o, 0);
        checkOutput("wr_strobe_c2", reg_wr_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        tick();
        checkOutput("wr_ack_drop", ack_o, 0);
        tick();

        // Read timeout with reg_rdy_i never asserted
        reg_rdy_i = 1'b0;
        reg_dat_i = 32'h11111111;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'd16, 32'h0);
        earlyAck = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            earlyAck += int'(ack_o);
        end
        checkOutput("to_no_early_ack", earlyAck, 0);
        checkOutput("to_err_c64", err_o, 0);
        tick();
        checkOutput("to_ack_c65", ack_o, 1);
        checkOutput("to_dat_c65", dat_o, 32'hDEADBEEF);
        checkOutput("to_err_c65", err_o, 1);
        checkOutput("ws3_to_ack_c65", ack3, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        tick();
        checkOutput("to_ack_drop", ack_o, 0);
        checkOutput("to_err_sticky", err_o, 1);
        tick();
        reg_rdy_i = 1'b1;
        reg_dat_i = 32'hABCD0123;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'd12, 32'h0);
        tick();
        checkOutput("to_err_cleared", err_o, 0);
        tick();
        checkOutput("to_next_dat", dat_o, 32'hABCD0123);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        tick();
        tick();

        // Abort during WAIT on the WAIT_STATES=3 instance
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'd20, 32'h0);
        tick();
        checkOutput("ab_stall3_c1", stall3, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'd20, 32'h0);
        tick();
        checkOutput("ab_stall3_c2", stall3, 0);
        checkOutput("ab_stall_c2", stall_o, 0);
        earlyAck = int'(ack_o) + int'(ack3);
        for (int i = 0; i < 4; i++) begin
            tick();
            earlyAck += int'(ack_o) + int'(ack3);
        end
        checkOutput("ab_no_ack", earlyAck, 0);

        // Misses: wrong window, then chip select low
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hFD0B0000, 32'h0);
        watchIdle(4, activity);
        checkOutput("miss_adr", activity, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, BASE + 32'd8, 32'h77);
        watchIdle(4, activity);
        checkOutput("miss_cs", activity, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        tick();

        // Read-modify-write: cyc_i held, stb_i low for one cycle between
        reg_dat_i = 32'h00000005;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
        tick();
        checkOutput("rmw_rd_strobe", reg_rd_o, 1);
        tick();
        checkOutput("rmw_rd_ack", ack_o, 1);
        checkOutput("rmw_rd_dat", dat_o, 32'h00000005);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
        tick();
        checkOutput("rmw_gap_ack", ack_o, 0);
        checkOutput("rmw_gap_dat", dat_o, 0);
        checkOutput("rmw_gap_stall", stall_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, BASE, 32'h00000006);
        tick();
        checkOutput("rmw_wr_strobe", reg_wr_o, 1);
        checkOutput("rmw_no_rd", reg_rd_o, 0);
        checkOutput("rmw_wr_regdat", reg_dat_o, 32'h00000006);
        checkOutput("rmw_wr_ack_c1", ack_o, FAST);
        tick();
        checkOutput("rmw_wr_ack_c2", ack_o, 1);
        checkOutput("rmw_wr_dat", dat_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        tick();
        checkOutput("rmw_wr_drop", ack_o, 0);
        tick();

        // Reset in the middle of a cycle abandons it
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'd8, 32'h0);
        tick();
        rst_i = 1'b1;
        tick();
        checkOutput("mrst_ack", ack_o, 0);
        checkOutput("mrst_stall", stall_o, 0);
        checkOutput("mrst_rd", reg_rd_o, 0);
        checkOutput("mrst_adr", reg_adr_o, 0);
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        tick();
        tick();
        checkOutput("mrst_no_ack", ack_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
